// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU op sequencer: opcodes, ALU control field values,
// the sequencer state enum and the packed control bundle handed to the ALU.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  localparam logic [2:0] FN_CLASS_IDLE  = 3'b000;
  localparam logic [2:0] FN_CLASS_ARITH = 3'b011;
  localparam logic [2:0] FN_CLASS_LOGIC = 3'b100;
  localparam logic [2:0] FN_CLASS_SHIFT = 3'b101;

  localparam logic [1:0] LOGIC_AND = 2'b00;
  localparam logic [1:0] LOGIC_OR  = 2'b01;
  localparam logic [1:0] LOGIC_XOR = 2'b10;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_READ = 2'b01,
    ST_EXEC = 2'b10,
    ST_WB   = 2'b11
  } state_t;

  typedef struct packed {
    logic       add_sub;
    logic       const_var;
    logic [1:0] logic_fn;
    logic [1:0] shift_fn;
    logic [2:0] fn_class;
  } alu_ctrl_t;

  localparam alu_ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode -> ALU control decode. Every opcode is covered and any
// field an op does not use is driven 0.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] i_op,
  output alu_ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = CTRL_IDLE;
    unique case (i_op)
      OP_ADD: begin
        o_ctrl.fn_class  = FN_CLASS_ARITH;
        o_ctrl.const_var = 1'b1;
      end
      OP_SUB: begin
        o_ctrl.fn_class  = FN_CLASS_ARITH;
        o_ctrl.add_sub   = 1'b1;
        o_ctrl.const_var = 1'b1;
      end
      OP_AND: begin
        o_ctrl.fn_class = FN_CLASS_LOGIC;
        o_ctrl.logic_fn = LOGIC_AND;
      end
      OP_OR: begin
        o_ctrl.fn_class = FN_CLASS_LOGIC;
        o_ctrl.logic_fn = LOGIC_OR;
      end
      OP_XOR: begin
        o_ctrl.fn_class = FN_CLASS_LOGIC;
        o_ctrl.logic_fn = LOGIC_XOR;
      end
      OP_SLL: begin
        o_ctrl.fn_class  = FN_CLASS_SHIFT;
        o_ctrl.shift_fn  = SHIFT_SLL;
        o_ctrl.const_var = 1'b1;
      end
      OP_SRL: begin
        o_ctrl.fn_class  = FN_CLASS_SHIFT;
        o_ctrl.shift_fn  = SHIFT_SRL;
        o_ctrl.const_var = 1'b1;
      end
      OP_SRA: begin
        o_ctrl.fn_class  = FN_CLASS_SHIFT;
        o_ctrl.shift_fn  = SHIFT_SRA;
        o_ctrl.const_var = 1'b1;
      end
      default: o_ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer: accepts one ALU op per handshake and walks it through
// READ, EXEC and WB, driving bank addresses, registered ALU controls and wr_en.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [3:0]        req_rd,
  input  logic [3:0]        req_rs,
  input  logic [3:0]        req_rt,
  output logic [REG_AW-1:0] rs_addr,
  output logic [REG_AW-1:0] rt_addr,
  output logic [REG_AW-1:0] rd_addr,
  output logic              wr_en,
  output logic              add_sub,
  output logic              const_var,
  output logic [1:0]        logic_fn,
  output logic [1:0]        shift_fn,
  output logic [2:0]        fn_class,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  op_count,
  output logic [1:0]        dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready
  // and rst is low; req_ready is high only in IDLE, and req_* are ignored otherwise.

  state_t           r_state;
  state_t           w_next_state;
  logic             w_accept;
  logic [2:0]       r_op;
  logic [3:0]       r_rd;
  logic [3:0]       r_rs;
  logic [3:0]       r_rt;
  alu_ctrl_t        r_ctrl;
  alu_ctrl_t        w_dec_ctrl;
  logic [CNT_W-1:0] r_count;

  alu_op_decode u_decode (
    .i_op   (r_op),
    .o_ctrl (w_dec_ctrl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept     = 1'b1;
          w_next_state = ST_READ;
        end
      end
      ST_READ: w_next_state = ST_EXEC;
      ST_EXEC: w_next_state = ST_WB;
      ST_WB:   w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Request latch, registered controls and completion counter. An op aborted by
  // reset never reaches WB, so it can neither write nor count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= OP_ADD;
      r_rd    <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_ctrl  <= CTRL_IDLE;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_op <= req_op;
        r_rd <= req_rd;
        r_rs <= req_rs;
        r_rt <= req_rt;
      end
      unique case (r_state)
        ST_READ: r_ctrl <= w_dec_ctrl;
        ST_WB: begin
          // Only the class drops back to idle; the other fields keep their last op.
          r_ctrl.fn_class <= FN_CLASS_IDLE;
          r_count         <= r_count + CNT_W'(1);
        end
        default: r_ctrl <= r_ctrl;
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign wr_en     = (r_state == ST_WB);
  assign done      = (r_state == ST_WB);
  assign rs_addr   = REG_AW'(r_rs);
  assign rt_addr   = REG_AW'(r_rt);
  assign rd_addr   = REG_AW'(r_rd);
  assign add_sub   = r_ctrl.add_sub;
  assign const_var = r_ctrl.const_var;
  assign logic_fn  = r_ctrl.logic_fn;
  assign shift_fn  = r_ctrl.shift_fn;
  assign fn_class  = r_ctrl.fn_class;
  assign op_count  = r_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a small register bank + ALU sits on the DUT outputs,
// and a plain-arithmetic model of registers, counter and control table predicts results.
module tb_alu_op_sequencer;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 5;
  localparam int PERIOD = 10;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [3:0]        req_rd;
  logic [3:0]        req_rs;
  logic [3:0]        req_rt;
  logic [REG_AW-1:0] rs_addr;
  logic [REG_AW-1:0] rt_addr;
  logic [REG_AW-1:0] rd_addr;
  logic              wr_en;
  logic              add_sub;
  logic              const_var;
  logic [1:0]        logic_fn;
  logic [1:0]        shift_fn;
  logic [2:0]        fn_class;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  op_count;
  logic [1:0]        dbg_state;

  alu_op_sequencer #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rd(req_rd), .req_rs(req_rs), .req_rt(req_rt),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .wr_en(wr_en),
    .add_sub(add_sub), .const_var(const_var), .logic_fn(logic_fn),
    .shift_fn(shift_fn), .fn_class(fn_class), .busy(busy), .done(done),
    .op_count(op_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  initial begin
    #(PERIOD * 20000);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- environment: register bank + ALU ----------------
  logic [15:0] bank [16];
  logic        pl_en;
  logic [3:0]  pl_addr;
  logic [15:0] pl_data;
  logic [15:0] alu_a, alu_b, alu_y;
  logic [3:0]  alu_amt;

  always_comb begin
    alu_a   = bank[rs_addr[3:0]];
    alu_b   = bank[rt_addr[3:0]];
    alu_amt = const_var ? alu_b[3:0] : 4'd1;
    alu_y   = 16'h0;
    case (fn_class)
      3'b011: alu_y = add_sub ? alu_a - alu_b : alu_a + alu_b;
      3'b100: case (logic_fn)
                2'b00:   alu_y = alu_a & alu_b;
                2'b01:   alu_y = alu_a | alu_b;
                2'b10:   alu_y = alu_a ^ alu_b;
                default: alu_y = 16'h0;
              endcase
      3'b101: case (shift_fn)
                2'b00:   alu_y = alu_a << alu_amt;
                2'b01:   alu_y = alu_a >> alu_amt;
                2'b10:   alu_y = $unsigned($signed(alu_a) >>> alu_amt);
                default: alu_y = 16'h0;
              endcase
      default: alu_y = 16'h0;
    endcase
  end

  always @(posedge clk) begin
    if (wr_en) bank[rd_addr[3:0]] <= alu_y;
    else if (pl_en) bank[pl_addr] <= pl_data;
  end

  // ---------------- reference model ----------------
  logic [15:0] model_regs [16];
  int          model_cnt;

  function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] x,
                                          input logic [15:0] y);
    int amt;
    amt = int'(y[3:0]);
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x ^ y;
      3'd5: return x << amt;
      3'd6: return x >> amt;
      default: return $unsigned($signed(x) >>> amt);
    endcase
  endfunction

  // {add_sub, const_var, logic_fn, shift_fn, fn_class}
  function automatic logic [8:0] exp_ctrl(input logic [2:0] op);
    case (op)
      3'd0: return {1'b0, 1'b1, 2'b00, 2'b00, 3'b011};
      3'd1: return {1'b1, 1'b1, 2'b00, 2'b00, 3'b011};
      3'd2: return {1'b0, 1'b0, 2'b00, 2'b00, 3'b100};
      3'd3: return {1'b0, 1'b0, 2'b01, 2'b00, 3'b100};
      3'd4: return {1'b0, 1'b0, 2'b10, 2'b00, 3'b100};
      3'd5: return {1'b0, 1'b1, 2'b00, 2'b00, 3'b101};
      3'd6: return {1'b0, 1'b1, 2'b00, 2'b01, 3'b101};
      default: return {1'b0, 1'b1, 2'b00, 2'b10, 3'b101};
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  int n_total;
  int n_bad;
  logic [19:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Every writeback must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 32'(wr_en), 32'd0);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        chk("wb_rd", 32'(rd_addr), 32'(e[19:16]));
        chk("wb_data", 32'(alu_y), 32'(e[15:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  time last_acc;
  bit  check_gap;

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
    model_regs[a] = d;
  endtask

  // Called at a negedge; returns at the negedge of the IDLE cycle after WB.
  task automatic run_op(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [3:0] rt, input bit keep_valid, input bit bp);
    int          w;
    logic [15:0] res;
    logic [8:0]  c;
    req_op = op; req_rd = rd; req_rs = rs; req_rt = rt;
    req_valid = 1'b1;
    w = 0;
    while (req_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (req_ready !== 1'b1) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    res = ref_alu(op, model_regs[rs], model_regs[rt]);
    exp_q.push_back({rd, res});
    @(posedge clk);
    if (check_gap) chk("accept_gap", 32'(($time - last_acc) / PERIOD), 32'd4);
    last_acc = $time;
    @(negedge clk);                                   // READ
    if (!keep_valid) req_valid = 1'b0;
    if (bp) begin
      req_valid = 1'b1;
      req_op = 3'($urandom_range(0, 7));
      req_rd = 4'($urandom_range(0, 15));
    end
    chk("read_wr_en", 32'(wr_en), 32'd0);
    chk("read_ready", 32'(req_ready), 32'd0);
    chk("read_busy", 32'(busy), 32'd1);
    chk("read_rs_addr", 32'(rs_addr), 32'(rs));
    chk("read_rt_addr", 32'(rt_addr), 32'(rt));
    @(negedge clk);                                   // EXEC
    chk("exec_wr_en", 32'(wr_en), 32'd0);
    chk("exec_ready", 32'(req_ready), 32'd0);
    @(negedge clk);                                   // WB
    if (bp) req_valid = 1'b0;
    c = exp_ctrl(op);
    chk("wb_wr_en", 32'(wr_en), 32'd1);
    chk("wb_done", 32'(done), 32'd1);
    chk("wb_rd_addr", 32'(rd_addr), 32'(rd));
    chk("wb_ctrl", 32'({add_sub, const_var, logic_fn, shift_fn, fn_class}), 32'(c));
    model_regs[rd] = res;
    model_cnt = (model_cnt + 1) % (1 << CNT_W);
    @(negedge clk);                                   // IDLE
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_wr_en", 32'(wr_en), 32'd0);
    chk("idle_fn_class", 32'(fn_class), 32'd0);
    chk("idle_rs_hold", 32'(rs_addr), 32'(rs));
    chk("op_count", 32'(op_count), 32'(model_cnt));
    chk("bank_rd", 32'(bank[rd]), 32'(res));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rd = '0; req_rs = '0; req_rt = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    n_total = 0; n_bad = 0; model_cnt = 0; check_gap = 1'b0; last_acc = 0;
    for (int i = 0; i < 16; i++) model_regs[i] = '0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fn_class", 32'(fn_class), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_addrs", 32'({rs_addr, rt_addr, rd_addr}), 32'd0);
    chk("rst_ctrl", 32'({add_sub, const_var, logic_fn, shift_fn}), 32'd0);

    for (int i = 0; i < 16; i++) preload(4'(i), 16'($urandom_range(0, 65535)));

    // Directed add: R1=5, R2=7 -> R3=12
    preload(4'd1, 16'd5);
    preload(4'd2, 16'd7);
    run_op(3'd0, 4'd3, 4'd1, 4'd2, 1'b0, 1'b0);
    chk("add_r3", 32'(bank[3]), 32'd12);
    chk("add_count", 32'(op_count), 32'd1);

    // Aliasing: R4=3, R4 = R4 + R4
    preload(4'd4, 16'd3);
    run_op(3'd0, 4'd4, 4'd4, 4'd4, 1'b0, 1'b0);
    chk("alias_r4", 32'(bank[4]), 32'd6);

    // Decode sweep, back-to-back with req_valid held high
    for (int i = 0; i < 8; i++) begin
      check_gap = (i != 0);
      run_op(3'(i), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), (i != 7), 1'b0);
    end
    check_gap = 1'b0;

    // Backpressure: stray requests during READ/EXEC must be ignored
    run_op(3'd1, 4'd5, 4'd6, 4'd7, 1'b0, 1'b1);
    @(negedge clk);
    chk("bp_no_accept", 32'(busy), 32'd0);

    // Random ops, long enough to wrap the counter
    for (int i = 0; i < 30; i++) begin
      run_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 1'b0);
      if (model_cnt == 0) chk("count_wrap", 32'(op_count), 32'd0);
    end

    // Reset and req_valid together: reset wins
    rst = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    model_cnt = 0;
    chk("rstv_busy", 32'(busy), 32'd0);
    chk("rstv_count", 32'(op_count), 32'd0);
    @(negedge clk);
    chk("rstv_busy2", 32'(busy), 32'd0);

    // Reset mid-op (asserted in EXEC): no writeback, dest unchanged
    preload(4'd9, 16'h1234);
    req_op = 3'd0; req_rd = 4'd9; req_rs = 4'd1; req_rt = 4'd2; req_valid = 1'b1;
    @(negedge clk);                                   // READ
    req_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd1);
    @(negedge clk);                                   // EXEC
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_idle", 32'(req_ready), 32'd1);
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    chk("abort_fn_class", 32'(fn_class), 32'd0);
    chk("abort_addrs", 32'({rs_addr, rt_addr, rd_addr}), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_r9", 32'(bank[9]), 32'h1234);
    chk("abort_count", 32'(op_count), 32'd0);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 16; i++) chk("final_bank", 32'(bank[i]), 32'(model_regs[i]));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
